ascon_stream_ctrl: RTL and testbench

Byte-stream front end for the Ascon AEAD core. It collects key, nonce, associated data, input data and, on decrypt, the expected tag over a byte-wide valid/ready port, then drives the core's flat-vector interface and its two-pulse start handshake. It returns the results as a byte stream. On decrypt it performs the tag comparison and withholds plaintext if the tag fails. It sits between the host/bus bridge and the core instance.

---
 rtl/ascon_stream_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ascon_stream_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_stream_ctrl.sv
// Byte-stream front end for the Ascon AEAD core: loads key, nonce, AD, data and
// (on decrypt) the expected tag over a byte port, runs the core's two-pulse start
// handshake, checks the tag on decrypt and streams the results back out.
module ascon_stream_ctrl #(
    parameter int unsigned K = 128,
    parameter int unsigned L = 40,
    parameter int unsigned Y = 40,
    // Zero-length fields still need a legal vector; the extra bit is tied to 0.
    localparam int unsigned LW = (L > 0) ? L : 1,
    localparam int unsigned YW = (Y > 0) ? Y : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic          cmd_decrypt,
    output logic          cmd_ready,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          tag_ok,
    output logic          busy,
    output logic [K-1:0]  core_key,
    output logic [127:0]  core_nonce,
    output logic [LW-1:0] core_ad,
    output logic [YW-1:0] core_din,
    output logic          core_decrypt,
    output logic          core_start,
    input  logic [YW-1:0] core_dout,
    input  logic [127:0]  core_tag,
    input  logic          core_ready
);

    localparam int unsigned KB     = K / 8;
    localparam int unsigned DB     = Y / 8;
    localparam int unsigned LdEnc  = KB + 16 + L / 8 + DB;
    localparam int unsigned LdDec  = LdEnc + 16;
    localparam int unsigned LdBits = 8 * LdDec;
    localparam int unsigned CW     = $clog2(LdDec + 1);
    localparam int unsigned IW     = $clog2(LdBits);
    // Send frame: status/data/tag bytes, MSB-first, shifted out of the top.
    localparam int unsigned SW     = Y + 136;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StRelease, StSend} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dec_q;
    logic               tag_ok_q;
    logic [LdBits-1:0]  load_q;
    logic [SW-1:0]      sbuf_q;
    logic [IW-1:0]      wr_lsb;
    logic [CW-1:0]      ld_last, send_last;
    logic [SW-1:0]      enc_frame, pass_frame;
    logic               capture, tag_match;

    // Load buffer layout, top down: key, nonce, AD, data, expected tag.
    assign core_key     = load_q[256+Y+L +: K];
    assign core_nonce   = load_q[128+Y+L +: 128];
    assign core_decrypt = dec_q;
    assign tag_match    = (core_tag == load_q[127:0]);
    assign capture      = (state_q == StWait) && core_ready;

    if (L > 0) begin : g_ad
        assign core_ad = load_q[128+Y +: L];
    end else begin : g_no_ad
        assign core_ad = '0;
    end

    if (Y > 0) begin : g_data
        assign core_din   = load_q[128 +: Y];
        assign enc_frame  = {core_dout, core_tag, 8'h00};
        assign pass_frame = {8'h01, core_dout, 128'h0};
    end else begin : g_no_data
        assign core_din   = '0;
        assign enc_frame  = {core_tag, 8'h00};
        assign pass_frame = {8'h01, 128'h0};
    end

    // Byte position in the load buffer and last-byte indices for LOAD and SEND
    always_comb begin
        wr_lsb    = IW'(LdBits - 8) - IW'({cnt_q, 3'b000});
        ld_last   = dec_q ? CW'(LdDec - 1) : CW'(LdEnc - 1);
        send_last = '0;
        if (!dec_q) begin
            send_last = CW'(DB + 15);
        end else if (tag_ok_q) begin
            send_last = CW'(DB);
        end
    end

    // Next-state and byte counter; the counter restarts at 0 on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    if (cnt_q == ld_last) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StStart:   state_d = StWait;
            StWait:    if (core_ready) state_d = StRelease;
            StRelease: state_d = StSend;
            StSend: begin
                if (out_ready) begin
                    if (cnt_q == send_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter, latched mode and tag verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            tag_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && cmd_valid) begin
                dec_q    <= cmd_decrypt;
                tag_ok_q <= 1'b0;
            end
            if (capture && dec_q) begin
                tag_ok_q <= tag_match;
            end
        end
    end

    // Holding registers filled byte by byte, first byte of a field at its MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q <= '0;
        end else if (state_q == StLoad && in_valid) begin
            load_q[wr_lsb +: 8] <= in_data;
        end
    end

    // Result frame: captured once from the core, then shifted out a byte per transfer.
    // A failed tag captures all zeros so plaintext never reaches the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf_q <= '0;
        end else if (capture) begin
            if (!dec_q) begin
                sbuf_q <= enc_frame;
            end else if (tag_match) begin
                sbuf_q <= pass_frame;
            end else begin
                sbuf_q <= '0;
            end
        end else if (state_q == StSend && out_ready) begin
            sbuf_q <= {sbuf_q[SW-9:0], 8'h00};
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign in_ready   = (state_q == StLoad);
    assign out_valid  = (state_q == StSend);
    assign core_start = (state_q == StStart) || (state_q == StRelease);
    assign out_data   = sbuf_q[SW-1 -: 8];
    assign tag_ok     = tag_ok_q;

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// Self-checking bench for ascon_stream_ctrl: a default-size instance and an
// L = 0 / Y = 0 instance, each with a core stub and an output scoreboard.
module tb_ascon_stream_ctrl;

    localparam int unsigned K = 128;
    localparam int unsigned L = 40;
    localparam int unsigned Y = 40;
    localparam logic [127:0] StubTag = 128'h00112233445566778899AABBCCDDEEFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-size instance
    logic         cmd_valid = 1'b0, cmd_decrypt = 1'b0, cmd_ready;
    logic [7:0]   in_data = 8'h00, out_data;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, tag_ok, busy;
    logic [K-1:0] core_key;
    logic [127:0] core_nonce, core_tag;
    logic [L-1:0] core_ad;
    logic [Y-1:0] core_din, core_dout;
    logic         core_decrypt, core_start, core_ready;

    // Zero-length instance
    logic         cmd_valid_z = 1'b0, cmd_decrypt_z = 1'b0, cmd_ready_z;
    logic [7:0]   in_data_z = 8'h00, out_data_z;
    logic         in_valid_z = 1'b0, in_ready_z, out_valid_z, out_ready_z = 1'b1;
    logic         tag_ok_z, busy_z;
    logic [K-1:0] core_key_z;
    logic [127:0] core_nonce_z;
    logic [0:0]   core_ad_z, core_din_z, core_dout_z;
    logic         core_decrypt_z, core_start_z, core_ready_z;

    assign core_tag    = StubTag;
    assign core_dout   = core_din ^ {(Y / 8){8'h5A}};
    assign core_dout_z = core_din_z;

    ascon_stream_ctrl #(.K(K), .L(L), .Y(Y)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_decrypt(cmd_decrypt), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tag_ok(tag_ok), .busy(busy),
        .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_din(core_din),
        .core_decrypt(core_decrypt), .core_start(core_start),
        .core_dout(core_dout), .core_tag(core_tag), .core_ready(core_ready)
    );

    ascon_stream_ctrl #(.K(K), .L(0), .Y(0)) dut_z (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_z), .cmd_decrypt(cmd_decrypt_z), .cmd_ready(cmd_ready_z),
        .in_data(in_data_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .out_data(out_data_z), .out_valid(out_valid_z), .out_ready(out_ready_z),
        .tag_ok(tag_ok_z), .busy(busy_z),
        .core_key(core_key_z), .core_nonce(core_nonce_z), .core_ad(core_ad_z),
        .core_din(core_din_z), .core_decrypt(core_decrypt_z), .core_start(core_start_z),
        .core_dout(core_dout_z), .core_tag(core_tag), .core_ready(core_ready_z)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_qz[$];
    bit         bp = 1'b0;
    int         n_start = 0, n_start_z = 0, start_base = 0;
    bit         start_prev = 1'b0, start_prev_z = 1'b0, start_wide = 1'b0, start_wide_z = 1'b0;
    bit         stall_prev = 1'b0, stall_prev_z = 1'b0;
    logic [7:0] data_prev = 8'h00, data_prev_z = 8'h00;
    bit         stub_run = 1'b0, stub_run_z = 1'b0;
    int         stub_cnt = 0, stub_cnt_z = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Core stubs: ready 20 cycles after the first start pulse, held until the release pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready <= 1'b0; stub_run <= 1'b0; stub_cnt <= 0;
        end else if (core_ready) begin
            if (core_start) core_ready <= 1'b0;
        end else if (stub_run) begin
            if (stub_cnt == 19) begin core_ready <= 1'b1; stub_run <= 1'b0; end
            stub_cnt <= stub_cnt + 1;
        end else if (core_start) begin
            stub_run <= 1'b1; stub_cnt <= 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready_z <= 1'b0; stub_run_z <= 1'b0; stub_cnt_z <= 0;
        end else if (core_ready_z) begin
            if (core_start_z) core_ready_z <= 1'b0;
        end else if (stub_run_z) begin
            if (stub_cnt_z == 19) begin core_ready_z <= 1'b1; stub_run_z <= 1'b0; end
            stub_cnt_z <= stub_cnt_z + 1;
        end else if (core_start_z) begin
            stub_run_z <= 1'b1; stub_cnt_z <= 0;
        end
    end

    // Output monitors: pick out_ready for the coming edge, then score the byte it takes
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); stall_prev = 1'b0; start_prev = 1'b0;
        end else begin
            if (core_start) begin n_start++; if (start_prev) start_wide = 1'b1; end
            start_prev = core_start;
            if (stall_prev) begin
                check("out_valid held under stall", out_valid, 1'b1);
                check("out_data held under stall", out_data, data_prev);
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious out byte", out_valid, 1'b0);
                else check("out byte", out_data, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_qz.delete(); stall_prev_z = 1'b0; start_prev_z = 1'b0;
        end else begin
            if (core_start_z) begin n_start_z++; if (start_prev_z) start_wide_z = 1'b1; end
            start_prev_z = core_start_z;
            if (stall_prev_z) begin
                check("z out_valid held under stall", out_valid_z, 1'b1);
                check("z out_data held under stall", out_data_z, data_prev_z);
            end
            out_ready_z = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid_z && out_ready_z) begin
                if (exp_qz.size() == 0) check("z spurious out byte", out_valid_z, 1'b0);
                else check("z out byte", out_data_z, exp_qz.pop_front());
            end
            stall_prev_z = out_valid_z && !out_ready_z;
            data_prev_z  = out_data_z;
        end
    end

    function automatic logic get_cmd_ready(input bit z);  return z ? cmd_ready_z : cmd_ready;   endfunction
    function automatic logic get_in_ready(input bit z);   return z ? in_ready_z : in_ready;     endfunction
    function automatic logic get_out_valid(input bit z);  return z ? out_valid_z : out_valid;   endfunction
    function automatic logic get_busy(input bit z);       return z ? busy_z : busy;             endfunction
    function automatic logic get_tag_ok(input bit z);     return z ? tag_ok_z : tag_ok;         endfunction
    function automatic logic get_core_start(input bit z); return z ? core_start_z : core_start; endfunction
    function automatic logic get_core_ready(input bit z); return z ? core_ready_z : core_ready; endfunction
    function automatic int   qsize(input bit z);          return z ? exp_qz.size() : exp_q.size(); endfunction

    task automatic push_exp(input bit z, input logic [7:0] b);
        if (z) exp_qz.push_back(b); else exp_q.push_back(b);
    endtask

    task automatic drive_cmd(input bit z, input logic v, input logic dec);
        if (z) begin cmd_valid_z = v; cmd_decrypt_z = dec; end
        else begin cmd_valid = v; cmd_decrypt = dec; end
    endtask

    task automatic drive_in(input bit z, input logic v, input logic [7:0] d);
        if (z) begin in_valid_z = v; in_data_z = d; end
        else begin in_valid = v; in_data = d; end
    endtask

    // Issue a command, push the expected output bytes, feed the input stream
    task automatic start_op(input bit z, input bit dec, input bit bad, input bit gap,
                            input bit poke);
        logic [7:0] bytes[$];
        int         ab, db, t;
        logic       rdy;
        ab = z ? 0 : L / 8;
        db = z ? 0 : Y / 8;
        for (int i = 0; i < K / 8; i++) bytes.push_back(8'(i));
        for (int i = 0; i < 16; i++) bytes.push_back(8'(16 + i));
        for (int i = 0; i < ab; i++) bytes.push_back(8'(1 + i));
        for (int i = 0; i < db; i++) bytes.push_back(8'(32 + i));
        if (dec) begin
            for (int j = 0; j < 16; j++) bytes.push_back(8'(17 * j));
            if (bad) bytes[bytes.size() - 1] = 8'hFE;
            push_exp(z, bad ? 8'h00 : 8'h01);
            if (!bad) for (int i = 0; i < db; i++) push_exp(z, 8'(32 + i) ^ 8'h5A);
        end else begin
            for (int i = 0; i < db; i++) push_exp(z, 8'(32 + i) ^ 8'h5A);
            for (int j = 0; j < 16; j++) push_exp(z, 8'(17 * j));
        end
        start_base = z ? n_start_z : n_start;
        @(negedge clk);
        check("cmd_ready in idle", get_cmd_ready(z), 1'b1);
        drive_cmd(z, 1'b1, dec);
        @(negedge clk);
        drive_cmd(z, 1'b0, 1'b0);
        check("busy after command", get_busy(z), 1'b1);
        check("in_ready in load", get_in_ready(z), 1'b1);
        for (int idx = 0; idx < bytes.size(); idx++) begin
            if (gap && $urandom_range(0, 2) == 0) begin
                drive_in(z, 1'b0, 8'h00);
                @(negedge clk);
            end
            if (poke && (idx % 5 == 2)) drive_cmd(z, 1'b1, !dec);
            else drive_cmd(z, 1'b0, 1'b0);
            drive_in(z, 1'b1, bytes[idx]);
            t = 0;
            do begin
                rdy = get_in_ready(z);
                @(negedge clk);
                t++;
            end while (!rdy && t < 20);
            if (!rdy) check("in_ready timeout", rdy, 1'b1);
        end
        drive_in(z, 1'b0, 8'h00);
        drive_cmd(z, 1'b0, 1'b0);
        check("core_start right after last byte", get_core_start(z), 1'b1);
    endtask

    // Wait for the core answer and check RELEASE / first output timing
    task automatic finish_op(input bit z, input bit dec);
        int t = 0;
        while (!get_core_ready(z) && t < 100) begin @(negedge clk); t++; end
        check("core_ready seen", get_core_ready(z), 1'b1);
        check("core_start low in wait", get_core_start(z), 1'b0);
        @(negedge clk);
        check("release pulse", get_core_start(z), 1'b1);
        check("out_valid low in release", get_out_valid(z), 1'b0);
        if (!z) begin
            check("core_key", core_key, 128'h000102030405060708090A0B0C0D0E0F);
            check("core_nonce", core_nonce, 128'h101112131415161718191A1B1C1D1E1F);
            check("core_ad", core_ad, 40'h0102030405);
            check("core_din", core_din, 40'h2021222324);
            check("core_decrypt", core_decrypt, dec);
        end
        @(negedge clk);
        check("out_valid two cycles after ready", get_out_valid(z), 1'b1);
    endtask

    task automatic drain(input bit z, input logic exp_tag_ok);
        int t = 0;
        while (qsize(z) != 0 && t < 300) begin @(negedge clk); t++; end
        check("all expected bytes sent", qsize(z), 0);
        @(negedge clk);
        check("busy low after last byte", get_busy(z), 1'b0);
        check("cmd_ready after op", get_cmd_ready(z), 1'b1);
        check("tag_ok", get_tag_ok(z), exp_tag_ok);
        check("core_start pulse count", (z ? n_start_z : n_start) - start_base, 2);
        check("core_start one cycle wide", z ? start_wide_z : start_wide, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1'b1);
        check({tag, " in_ready"}, in_ready, 1'b0);
        check({tag, " out_valid"}, out_valid, 1'b0);
        check({tag, " core_start"}, core_start, 1'b0);
        check({tag, " tag_ok"}, tag_ok, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " out_data"}, out_data, 8'h00);
        check({tag, " core_key"}, core_key, 128'h0);
        check({tag, " z busy"}, busy_z, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must drop without waiting for a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_checks(tag);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_checks("power-on");
        #2 rst = 1'b0;

        // Encrypt with defaults; stray in_valid while idle must be ignored
        @(negedge clk);
        drive_in(1'b0, 1'b1, 8'hEE);
        repeat (3) @(negedge clk);
        check("in_ready low in idle", in_ready, 1'b0);
        drive_in(1'b0, 1'b0, 8'h00);
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); finish_op(1'b0, 1'b0); drain(1'b0, 1'b0);

        // Decrypt, matching tag
        start_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); finish_op(1'b0, 1'b1); drain(1'b0, 1'b1);

        // Decrypt, wrong tag: status byte only
        start_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); finish_op(1'b0, 1'b1); drain(1'b0, 1'b0);

        // Backpressure on output, gaps on input
        bp = 1'b1;
        start_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); finish_op(1'b0, 1'b0); drain(1'b0, 1'b0);
        bp = 1'b0;

        // Reset in WAIT, then in SEND of a passing decrypt, then a clean encrypt
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        do_reset("reset in wait");
        start_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); finish_op(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("tag_ok before reset in send", tag_ok, 1'b1);
        do_reset("reset in send");
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); finish_op(1'b0, 1'b0); drain(1'b0, 1'b0);

        // Zero-length build: cmd_valid pokes during LOAD are ignored
        start_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); finish_op(1'b1, 1'b0); drain(1'b1, 1'b0);
        start_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); finish_op(1'b1, 1'b1); drain(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
